// File: rtl/matmul_scheduler.sv
// Sequencer for a run-time sized NxN matrix multiply: walks (i,j) row-major, issues
// N load/mult/acc triplets per element and writes each result over valid/ready.
// Optional stall counter output enabled by defining MATMUL_STALL_COUNT_EN.
module matmul_scheduler #(
    parameter  int SIZE = 4,
    localparam int IW   = $clog2(SIZE),
    localparam int DW   = $clog2(SIZE) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dim_in,
    input  logic          wr_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [IW-1:0] row_idx,
    output logic [IW-1:0] col_idx,
    output logic [IW-1:0] k_idx,
    output logic          acc_clr,
    output logic          load_en,
    output logic          mult_en,
    output logic          acc_en,
`ifdef MATMUL_STALL_COUNT_EN
    output logic [15:0]   stall_cnt,
`endif
    output logic          wr_en
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_MULT  = 3'd3;
    localparam logic [2:0] S_ACC   = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [DW-1:0] DIM_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DIM_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] DIM_MAX  = DW'(SIZE);
    localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};

    logic [2:0]    r_state;
    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [IW-1:0] r_k;
    logic [DW-1:0] r_n;

    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_acc_clr;
    logic          r_load_en;
    logic          r_mult_en;
    logic          r_acc_en;
    logic          r_wr_en;

    logic [2:0]    w_state_nxt;
    logic [IW-1:0] w_i_nxt;
    logic [IW-1:0] w_j_nxt;
    logic [IW-1:0] w_k_nxt;
    logic [DW-1:0] w_n_nxt;
    logic [DW-1:0] w_n_m1;
    logic          w_dim_ok;
    logic          w_start_ok;
    logic          w_start_bad;
    logic          w_last_i;
    logic          w_last_j;
    logic          w_last_k;
    logic          w_xfer;

    assign w_dim_ok    = (dim_in != DIM_ZERO) && (dim_in <= DIM_MAX);
    assign w_start_ok  = (r_state == S_IDLE) && start && w_dim_ok;
    assign w_start_bad = (r_state == S_IDLE) && start && !w_dim_ok;
    assign w_n_m1      = r_n - DIM_ONE;
    assign w_last_i    = ({1'b0, r_i} == w_n_m1);
    assign w_last_j    = ({1'b0, r_j} == w_n_m1);
    assign w_last_k    = ({1'b0, r_k} == w_n_m1);
    assign w_xfer      = (r_state == S_WRITE) && wr_ready;

    // Next-state and index update logic
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_n_nxt     = r_n;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_n_nxt     = dim_in;
                    w_i_nxt     = IDX_ZERO;
                    w_j_nxt     = IDX_ZERO;
                    w_k_nxt     = IDX_ZERO;
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_MULT;
            S_MULT:  w_state_nxt = S_ACC;
            S_ACC: begin
                if (w_last_k) begin
                    w_k_nxt     = IDX_ZERO;
                    w_state_nxt = S_WRITE;
                end else begin
                    w_k_nxt     = r_k + IDX_ONE;
                    w_state_nxt = S_LOAD;
                end
            end
            S_WRITE: begin
                // Without a transfer everything holds, so wr_en is never retracted
                if (!w_xfer) begin
                    w_state_nxt = S_WRITE;
                end else if (!w_last_j) begin
                    w_j_nxt     = r_j + IDX_ONE;
                    w_state_nxt = S_CLEAR;
                end else if (!w_last_i) begin
                    w_j_nxt     = IDX_ZERO;
                    w_i_nxt     = r_i + IDX_ONE;
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_i     <= IDX_ZERO;
            r_j     <= IDX_ZERO;
            r_k     <= IDX_ZERO;
            r_n     <= DIM_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_n     <= w_n_nxt;
        end
    end

    // Moore outputs registered from the next state so they align with the state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_acc_clr <= 1'b0;
            r_load_en <= 1'b0;
            r_mult_en <= 1'b0;
            r_acc_en  <= 1'b0;
            r_wr_en   <= 1'b0;
        end else begin
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            r_err     <= w_start_bad;
            r_acc_clr <= (w_state_nxt == S_CLEAR);
            r_load_en <= (w_state_nxt == S_LOAD);
            r_mult_en <= (w_state_nxt == S_MULT);
            r_acc_en  <= (w_state_nxt == S_ACC);
            r_wr_en   <= (w_state_nxt == S_WRITE);
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign acc_clr = r_acc_clr;
    assign load_en = r_load_en;
    assign mult_en = r_mult_en;
    assign acc_en  = r_acc_en;
    assign wr_en   = r_wr_en;
    assign row_idx = r_i;
    assign col_idx = r_j;
    assign k_idx   = r_k;

`ifdef MATMUL_STALL_COUNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of WRITE cycles refused by the result memory
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_start_ok) begin
            r_stall_cnt <= 16'h0000;
        end else if ((r_state == S_WRITE) && !wr_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_matmul_scheduler.sv
// Self-checking bench for matmul_scheduler: directed scenarios plus randomized jobs
// compared cycle by cycle against an operation-trace model built from nested loops.
module tb_matmul_scheduler;

    localparam int SIZE = 4;
    localparam int IW   = $clog2(SIZE);
    localparam int DW   = $clog2(SIZE) + 1;

    localparam int OP_CLR = 0;
    localparam int OP_LD  = 1;
    localparam int OP_MU  = 2;
    localparam int OP_AC  = 3;
    localparam int OP_WR  = 4;
    localparam int OP_DN  = 5;

    typedef struct {
        int op;
        int i;
        int j;
        int k;
    } step_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] dim_in;
    logic          wr_ready;
    logic          busy, done, err;
    logic [IW-1:0] row_idx, col_idx, k_idx;
    logic          acc_clr, load_en, mult_en, acc_en, wr_en;
`ifdef MATMUL_STALL_COUNT_EN
    logic [15:0]   stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    matmul_scheduler #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dim_in   (dim_in),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .row_idx  (row_idx),
        .col_idx  (col_idx),
        .k_idx    (k_idx),
        .acc_clr  (acc_clr),
        .load_en  (load_en),
        .mult_en  (mult_en),
        .acc_en   (acc_en),
`ifdef MATMUL_STALL_COUNT_EN
        .stall_cnt(stall_cnt),
`endif
        .wr_en    (wr_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // {busy,done,err,acc_clr,load_en,mult_en,acc_en,wr_en,row,col,k}
    function automatic logic [31:0] obs_vec();
        return 32'({busy, done, err, acc_clr, load_en, mult_en, acc_en, wr_en,
                    row_idx, col_idx, k_idx});
    endfunction

    function automatic logic [31:0] ctl_vec();
        return 32'({busy, done, err, acc_clr, load_en, mult_en, acc_en, wr_en});
    endfunction

    function automatic logic [31:0] mk_vec(input logic b, input logic d, input logic e,
                                           input logic [4:0] en, input int i, input int j,
                                           input int k);
        logic [IW-1:0] ii, jj, kk;
        ii = IW'(i);
        jj = IW'(j);
        kk = IW'(k);
        return 32'({b, d, e, en, ii, jj, kk});
    endfunction

    function automatic logic [31:0] step_vec(input step_t s);
        logic [4:0] en;
        en = 5'b00000;
        if (s.op != OP_DN) en = 5'b10000 >> s.op;
        return mk_vec(1'b1, (s.op == OP_DN), 1'b0, en, s.i, s.j, s.k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready; 1: refuse stall_n tries at element stall_el; 2: random
    task automatic run_job(input int n, input int mode, input int stall_el, input int stall_n,
                           input bit mid_start, input string tag);
        step_t q[$];
        step_t s;
        int    cyc, stalls, el, tries;
        bit    rdy;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                q.push_back('{OP_CLR, i, j, 0});
                for (int k = 0; k < n; k++) begin
                    q.push_back('{OP_LD, i, j, k});
                    q.push_back('{OP_MU, i, j, k});
                    q.push_back('{OP_AC, i, j, k});
                end
                q.push_back('{OP_WR, i, j, 0});
            end
        end
        q.push_back('{OP_DN, n - 1, n - 1, 0});

        start  = 1'b1;
        dim_in = DW'(n);
        tick();
        start  = 1'b0;
        dim_in = DW'($urandom_range(0, 7));
        cyc = 1; stalls = 0; el = 0; tries = 0;
        while (q.size() > 0 && cyc < 2000) begin
            s = q[0];
            chk({tag, ":trace"}, obs_vec(), step_vec(s));
            if (s.op != OP_DN)
                chk({tag, ":onehot"}, 32'($countones({acc_clr, load_en, mult_en, acc_en, wr_en})),
                    32'd1);
            else
                chk({tag, ":done_cycle"}, 32'(cyc), 32'(n * n * (3 * n + 2) + 1 + stalls));
            if (s.op == OP_WR) begin
                case (mode)
                    1:       rdy = !(el == stall_el && tries < stall_n);
                    2:       rdy = ($urandom_range(0, 3) != 0);
                    default: rdy = 1'b1;
                endcase
                tries++;
                if (!rdy) stalls++;
            end else begin
                rdy = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (mid_start) begin
                start  = (cyc == 7);
                dim_in = (n == 1) ? DW'(2) : DW'(1);
            end
            wr_ready = rdy;
            tick();
            cyc++;
            if (s.op != OP_WR || rdy) begin
                void'(q.pop_front());
                if (s.op == OP_WR) begin
                    el++;
                    tries = 0;
                end
            end
        end
        start    = 1'b0;
        wr_ready = 1'b1;
        chk({tag, ":completed"}, 32'(q.size()), 32'd0);
        chk({tag, ":idle_after"}, obs_vec(), mk_vec(1'b0, 1'b0, 1'b0, 5'b00000, n - 1, n - 1, 0));
`ifdef MATMUL_STALL_COUNT_EN
        chk({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(stalls));
`endif
    endtask

    initial begin
        bit found;
        int seen_busy_done;
        reset = 1'b0; start = 1'b0; dim_in = '0; wr_ready = 1'b1;
        repeat (3) tick();
        chk("reset_state", obs_vec(), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_after_reset", obs_vec(), 32'd0);

        run_job(1, 0, 0, 0, 1'b0, "n1");
        run_job(2, 0, 0, 0, 1'b0, "n2");
        run_job(2, 1, 1, 3, 1'b0, "n2_stall");

        // Invalid dimensions: 0, SIZE+1 and the remaining out-of-range codes
        for (int t = 0; t < 4; t++) begin
            start  = 1'b1;
            dim_in = (t == 0) ? DW'(0) : DW'(SIZE + t);
            tick();
            start = 1'b0;
            chk("bad_dim_err", ctl_vec(), 32'b00100000);
            tick();
            chk("bad_dim_quiet", ctl_vec(), 32'd0);
        end

        // Reset in MULT of element (1,0) for N=4
        start = 1'b1; dim_in = DW'(4);
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            if (mult_en && row_idx == IW'(1) && col_idx == IW'(0)) found = 1'b1;
            else tick();
        end
        chk("reach_mult_10", 32'(found), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_outputs", obs_vec(), 32'd0);
        seen_busy_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy || done || wr_en) seen_busy_done++;
        end
        chk("abort_quiet", 32'(seen_busy_done), 32'd0);
        run_job(1, 0, 0, 0, 1'b0, "after_abort");

        run_job(3, 0, 0, 0, 1'b1, "mid_start");

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, SIZE);
            run_job(n, 2, 0, 0, (n >= 2) && ($urandom_range(0, 1) == 1), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matmul_scheduler.md
Name: matmul_scheduler

Overview:
- Top-level sequencer for an NxN by NxN matrix multiply, where N = 1..SIZE is set at run time.
- Walks every output element (i,j) in row-major order. For each element it drives N load/mult/acc triplets into the shared MAC datapath and supplies the row, column and k indices used to address the A and B memories.
- Hands each finished dot product to the result memory over a valid/ready write handshake.
- Sits between the host start/done interface and the MAC datapath plus operand and result memories.

Parameters:
- SIZE, 4, maximum matrix dimension; index width IW = $clog2(SIZE), dimension width DW = $clog2(SIZE)+1

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a job; sampled only in IDLE
- dim_in  in  DW  matrix dimension N; valid range 1..SIZE; latched on an accepted start
- wr_ready  in  1  result memory can accept a write
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the job completes
- err  out  1  one-cycle pulse when start is rejected because dim_in is out of range
- row_idx  out  IW  i, the A row and the result row
- col_idx  out  IW  j, the B column and the result column
- k_idx  out  IW  k, the A column and the B row
- acc_clr  out  1  clears the MAC accumulator
- load_en  out  1  MAC operand load
- mult_en  out  1  MAC multiply
- acc_en  out  1  MAC accumulate
- wr_en  out  1  result write valid

Behaviour:
- All outputs are registered, Moore style, and decoded from state and counters.
- Reset (reset==0 at a rising edge):
  - state goes to IDLE; i, j, k and the latched N go to 0.
  - Every output is 0.
  - Reset has priority over everything, including mid-job. An aborted job produces no done and no further wr_en.
- States: IDLE, CLEAR, LOAD, MULT, ACC, WRITE, DONE.
- IDLE:
  - start=1 with 1<=dim_in<=SIZE: latch N=dim_in; set i=j=k=0; go to CLEAR.
  - start=1 with dim_in==0 or dim_in>SIZE: err=1 for the next cycle only; stay in IDLE.
  - start=0: stay in IDLE.
- CLEAR: acc_clr=1; go to LOAD.
- LOAD: load_en=1; go to MULT.
- MULT: mult_en=1; go to ACC.
- ACC: acc_en=1.
  - k==N-1: k<=0; go to WRITE.
  - Otherwise: k<=k+1; go to LOAD.
- WRITE: wr_en=1 until the transfer completes. A transfer is wr_en && wr_ready in the same cycle.
  - On transfer with j<N-1: j<=j+1; go to CLEAR.
  - On transfer with j==N-1 and i<N-1: j<=0; i<=i+1; go to CLEAR.
  - On transfer with i==N-1 and j==N-1: go to DONE.
  - No transfer: hold state and all indices. wr_en stays high (no retraction).
- DONE: done=1 for exactly one cycle; go to IDLE.
- Index outputs:
  - row_idx, col_idx and k_idx always reflect the current i, j and k.
  - They are stable throughout each LOAD/MULT/ACC triplet and throughout WRITE.
- Exactly one of acc_clr, load_en, mult_en, acc_en and wr_en is high in any cycle.
- start is ignored while busy=1. dim_in is ignored outside an accepted start.
- Latency with wr_ready held at 1:
  - Per element: 3N+2 cycles.
  - done is high in cycle N²(3N+2)+1 after the start-sampling edge.
  - Examples: 6 cycles for N=1; 33 cycles for N=2.
  - Each cycle of wr_ready=0 during WRITE adds exactly one cycle.
- Counters never wrap. Indices stay within 0..N-1.
- Back-to-back jobs: start may be accepted in the cycle after DONE, i.e. while in IDLE.

Optional Feature:
- Macro: MATMUL_STALL_COUNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - stall_cnt is cleared on reset and on an accepted start.
  - It increments once per cycle spent in WRITE with wr_ready=0, and saturates at 16'hFFFF.
  - It holds its value after done until the next accepted start.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- N=1, wr_ready=1, start pulse:
  - Expected sequence: acc_clr, load, mult, acc, wr_en.
  - All indices 0; done in cycle 6; busy=0 after done.
- N=2, wr_ready=1:
  - Writes occur in (i,j) order (0,0),(0,1),(1,0),(1,1).
  - Within each element, k steps 0 then 1.
  - Exactly 4 wr_en transfers; done in cycle 33.
  - Exactly one enable high in every cycle.
- N=2, wr_ready=0 for 3 cycles at element (0,1):
  - wr_en and indices are held during the stall.
  - done in cycle 36; stall_cnt=3 when the macro is defined.
- Invalid dimension:
  - start with dim_in=0: err pulses once; busy stays 0.
  - start with dim_in=5 (SIZE=4): same response.
  - In both cases no enables and no done.
- Reset during a job: reset=0 while in MULT of element (1,0) with N=4.
  - The next cycle has all outputs 0 and the block in IDLE.
  - No done follows.
  - A new start with N=1 completes in 6 cycles.
- start pulsed mid-job and with a different dim_in: ignored. The job completes with the original N and done at the expected cycle.
